keypad_matrix_responder: RTL
============================

// Module: keypad_matrix_responder
// PURPOSE
//  Key-matrix responder for the 3x4 keypad interface: drives key_row in answer to the
//  one-hot column strobes (key_col) issued by the keypad scanner, emulating a physical
//  key press. Used for self-test and scripted game replay in place of the real keypad.
//  Accepts one key-press command at a time via valid/ready; reports completion and the
//  number of matched column strobes.
// PARAMETERS
//  HOLD_W      16   width of cmd_hold (press duration in clk cycles)
//  GAP_CYCLES  2500 release time after each press, in clk cycles; legal range >= 1
// PORTS
//  clk        in   1       system clock (25 MHz)
//  rst        in   1       synchronous, active-high reset
//  key_col    in   3       column strobe from scanner: 001=col1, 010=col2, 100=col3
//  cmd_valid  in   1       command request
//  cmd_key    in   4       key code: 0-9 digits, 10='*', 11='#'
//  cmd_hold   in   HOLD_W  press duration in cycles; 0 is treated as 1
//  cmd_ready  out  1       high in IDLE only
//  key_row    out  4       row response to scanner (one-hot or 0)
//  busy       out  1       high in PRESS or GAP
//  done       out  1       1-cycle pulse when a command completes
//  cmd_err    out  1       1-cycle pulse when an invalid key code is offered
//  hit_cnt    out  8       matched-strobe cycles in the current/last press, saturating at 255
// BEHAVIOUR
//  Reset: one clock and one synchronous active-high reset (clk, rst); all state updates
//   on posedge clk. rst=1 -> state IDLE, key_row=0, cmd_ready=1, busy=0, done=0,
//   cmd_err=0, hit_cnt=0, all counters 0. Reset mid-PRESS/GAP aborts with no done pulse.
//  Key map (column, row): 1=(001,0001) 4=(001,0010) 7=(001,0100) *=(001,1000)
//   2=(010,0001) 5=(010,0010) 8=(010,0100) 0=(010,1000)
//   3=(100,0001) 6=(100,0010) 9=(100,0100) #=(100,1000)
//  FSM IDLE -> PRESS -> GAP -> IDLE.
//  IDLE: cmd_ready=1. Accept on cmd_valid at a posedge.
//   cmd_key>11 -> cmd_err=1 for one cycle; stay IDLE; nothing latched.
//   Else latch key; hold_cnt <= max(cmd_hold,1); hit_cnt <= 0; go to PRESS.
//  PRESS (entered at edge N): lasts exactly H=max(cmd_hold,1) cycles; left at edge N+H.
//   Decrement hold_cnt each cycle. Go to GAP when hold_cnt==1; load gap_cnt=GAP_CYCLES.
//  key_row is registered.
//   At each edge: key_row <= (state==PRESS && key_col==col(key)) ? row(key) : 0.
//   Result: nonzero possible at edges N+1..N+H; 0 from edge N+H+1.
//   key_col that is not one-hot (000, 011, 111, ...) never matches.
//  hit_cnt increments, saturating at 255, on every edge where key_row is loaded nonzero.
//   It holds its value after the press until the next accept.
//  GAP: key_row=0 for exactly GAP_CYCLES cycles. IDLE is reached at edge N+H+GAP_CYCLES.
//   At that edge: done=1 for one cycle, cmd_ready=1 in the same cycle.
//  Boundaries:
//   cmd_valid while busy is ignored (ready=0; no error, no queuing).
//   A new command may be accepted on the cycle done is high.
//   hold_cnt and gap_cnt never wrap.
//   cmd_hold=all-ones is legal: 2^HOLD_W-1 cycles.
// TESTING
//  1 key_col=010 held, cmd key=5 hold=4 accepted at edge N -> key_row=0010 at edges
//    N+1..N+4, 0 at N+5; hit_cnt=4; done at N+4+GAP_CYCLES.
//  2 key_col rotates 001->010->100 each cycle, key=11('#') hold=9 -> key_row=1000 only
//    one edge after each 100 strobe; hit_cnt=3.
//  3 key_col=001 constant, key=2 hold=6 -> key_row stays 0000; hit_cnt=0; done still pulses.
//  4 cmd_key=13 in IDLE -> cmd_err=1 for 1 cycle; cmd_ready stays 1; key_row 0; no done.
//  5 rst=1 two cycles into PRESS -> next edge key_row=0, cmd_ready=1, busy=0, hit_cnt=0, no done.
//  6 cmd_hold=0 with key_col=100, key=9 -> one cycle PRESS, key_row=0100 once;
//    cmd_valid during GAP ignored.

Source files
------------

// File: rtl/keypad_matrix_responder_if.sv
// Command and keypad-matrix signal bundle between the keypad scanner side and the responder.
interface keypad_matrix_responder_if #(
    parameter int unsigned HOLD_W = 16
) ();
    logic [2:0]        key_col;
    logic              cmd_valid;
    logic [3:0]        cmd_key;
    logic [HOLD_W-1:0] cmd_hold;
    logic              cmd_ready;
    logic [3:0]        key_row;
    logic              busy;
    logic              done;
    logic              cmd_err;
    logic [7:0]        hit_cnt;

    modport master (
        output key_col, cmd_valid, cmd_key, cmd_hold,
        input  cmd_ready, key_row, busy, done, cmd_err, hit_cnt
    );

    modport slave (
        input  key_col, cmd_valid, cmd_key, cmd_hold,
        output cmd_ready, key_row, busy, done, cmd_err, hit_cnt
    );
endinterface

// File: rtl/keypad_matrix_responder.sv
// Emulates a 3x4 keypad key press: answers the scanner's one-hot column strobes with the
// row of the commanded key for a programmable hold time, then releases for a fixed gap.
module keypad_matrix_responder #(
    parameter int unsigned HOLD_W     = 16,
    parameter int unsigned GAP_CYCLES = 2500
) (
    input  logic                      clk,
    input  logic                      rst,
    keypad_matrix_responder_if.slave  kp
);

    localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int unsigned KEY_MAX = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e            state_q;
    logic [2:0]        col_q;
    logic [3:0]        row_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic [3:0]        key_row_q;
    logic [3:0]        key_row_d;
    logic [7:0]        hit_cnt_q;
    logic [7:0]        hit_cnt_d;
    logic              cmd_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              cmd_err_q;

    logic [2:0]        dec_col_c;
    logic [3:0]        dec_row_c;
    logic              key_ok_c;
    logic [HOLD_W-1:0] hold_eff_c;
    logic              accept_c;
    logic              col_match_c;

    // Key code to (column strobe, row response) of the physical keypad.
    always_comb begin
        dec_col_c = 3'b100;
        dec_row_c = 4'b1000;
        unique case (kp.cmd_key)
            4'd1:    begin dec_col_c = 3'b001; dec_row_c = 4'b0001; end
            4'd4:    begin dec_col_c = 3'b001; dec_row_c = 4'b0010; end
            4'd7:    begin dec_col_c = 3'b001; dec_row_c = 4'b0100; end
            4'd10:   begin dec_col_c = 3'b001; dec_row_c = 4'b1000; end
            4'd2:    begin dec_col_c = 3'b010; dec_row_c = 4'b0001; end
            4'd5:    begin dec_col_c = 3'b010; dec_row_c = 4'b0010; end
            4'd8:    begin dec_col_c = 3'b010; dec_row_c = 4'b0100; end
            4'd0:    begin dec_col_c = 3'b010; dec_row_c = 4'b1000; end
            4'd3:    begin dec_col_c = 3'b100; dec_row_c = 4'b0001; end
            4'd6:    begin dec_col_c = 3'b100; dec_row_c = 4'b0010; end
            4'd9:    begin dec_col_c = 3'b100; dec_row_c = 4'b0100; end
            default: begin dec_col_c = 3'b100; dec_row_c = 4'b1000; end
        endcase
    end

    // A latched column is always one-hot, so a multi-bit or empty strobe never compares equal.
    always_comb begin
        key_ok_c    = (kp.cmd_key <= 4'(KEY_MAX));
        hold_eff_c  = (kp.cmd_hold == '0) ? HOLD_W'(1) : kp.cmd_hold;
        accept_c    = (state_q == ST_IDLE) && kp.cmd_valid && key_ok_c;
        col_match_c = (state_q == ST_PRESS) && (kp.key_col == col_q);
        key_row_d   = col_match_c ? row_q : 4'b0000;

        hit_cnt_d = hit_cnt_q;
        if (accept_c) begin
            hit_cnt_d = 8'd0;
        end else if (col_match_c && (hit_cnt_q != 8'hFF)) begin
            hit_cnt_d = hit_cnt_q + 8'd1;
        end
    end

    // Press sequencer: IDLE -> PRESS (hold) -> GAP (release) -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            col_q       <= 3'b000;
            row_q       <= 4'b0000;
            hold_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            key_row_q   <= 4'b0000;
            hit_cnt_q   <= 8'd0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;
            key_row_q <= key_row_d;
            hit_cnt_q <= hit_cnt_d;

            unique case (state_q)
                ST_IDLE: begin
                    if (kp.cmd_valid) begin
                        if (key_ok_c) begin
                            col_q       <= dec_col_c;
                            row_q       <= dec_row_c;
                            hold_cnt_q  <= hold_eff_c;
                            state_q     <= ST_PRESS;
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                    end
                end

                ST_PRESS: begin
                    hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                    if (hold_cnt_q == HOLD_W'(1)) begin
                        gap_cnt_q <= GAP_W'(GAP_CYCLES);
                        state_q   <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    if (gap_cnt_q == GAP_W'(1)) begin
                        state_q     <= ST_IDLE;
                        done_q      <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign kp.key_row   = key_row_q;
    assign kp.hit_cnt   = hit_cnt_q;
    assign kp.cmd_ready = cmd_ready_q;
    assign kp.busy      = busy_q;
    assign kp.done      = done_q;
    assign kp.cmd_err   = cmd_err_q;

endmodule
